// File: rtl/stream_mux_rr.sv
// CH-input stream multiplexer with packet-level arbitration (round-robin or
// external select) and a registered, channel-tagged output stream.
module stream_mux_rr #(
   parameter int N    = 16,
   parameter int CH   = 4,
   parameter int MODE = 0,
   localparam int CW  = ($clog2(CH) > 0) ? $clog2(CH) : 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [CW-1:0]     sel_i,
   input  logic [CH-1:0]     in_valid_i,
   output logic [CH-1:0]     in_ready_o,
   input  logic [CH*N-1:0]   in_data_i,
   input  logic [CH-1:0]     in_last_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [N-1:0]      out_data_o,
   output logic              out_last_o,
   output logic [CW-1:0]     out_ch_o,
   output logic              busy_o
);

   // state  | meaning
   // IDLE   | no packet in progress, arbitrate among valid channels
   // LOCKED | grant held on lock_ch until its last beat is accepted
   typedef enum logic {ST_IDLE, ST_LOCKED} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   lock_ch_q, lock_ch_d;
   logic            out_valid_q, out_valid_d;
   logic [N-1:0]    out_data_q, out_data_d;
   logic            out_last_q, out_last_d;
   logic [CW-1:0]   out_ch_q, out_ch_d;

   logic            gnt_valid;
   logic [CW-1:0]   gnt;
   logic [CW-1:0]   gnt_inc;
   logic [N-1:0]    gnt_data;
   logic            gnt_last;
   logic            gnt_in_valid;
   logic            space;
   logic            accept;
   int              idx;

   always_comb begin
      gnt_valid = 1'b0;
      gnt       = '0;
      idx       = 0;
      if (state_q == ST_LOCKED) begin
         gnt_valid = 1'b1;
         gnt       = lock_ch_q;
      end else if (MODE == 0) begin
         // search ptr, ptr+1, ... wrapping; first valid channel wins
         for (int k = 0; k < CH; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= CH) idx = idx - CH;
            for (int i = 0; i < CH; i++) begin
               if (!gnt_valid && idx == i && in_valid_i[i]) begin
                  gnt_valid = 1'b1;
                  gnt       = CW'(i);
               end
            end
         end
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (sel_i == CW'(i) && in_valid_i[i]) begin
               gnt_valid = 1'b1;
               gnt       = CW'(i);
            end
         end
      end
   end

   always_comb begin
      gnt_data     = '0;
      gnt_last     = 1'b0;
      gnt_in_valid = 1'b0;
      for (int i = 0; i < CH; i++) begin
         if (gnt == CW'(i)) begin
            gnt_data     = in_data_i[i*N +: N];
            gnt_last     = in_last_i[i];
            gnt_in_valid = in_valid_i[i];
         end
      end
   end

   assign space   = ~out_valid_q | out_ready_i;
   assign accept  = ~reset_i & gnt_valid & space & gnt_in_valid;
   assign gnt_inc = (int'(gnt) == CH - 1) ? '0 : gnt + CW'(1);

   always_comb begin
      for (int i = 0; i < CH; i++) begin
         in_ready_o[i] = ~reset_i & gnt_valid & (gnt == CW'(i)) & space;
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      lock_ch_d   = lock_ch_q;
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      out_ch_d    = out_ch_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = gnt_data;
         out_last_d  = gnt_last;
         out_ch_d    = gnt;
      end else if (out_ready_i) begin
         out_valid_d = 1'b0;
      end
      // ptr only advances when a packet completes
      if (accept) begin
         case (state_q)
            ST_IDLE: begin
               if (gnt_last) begin
                  ptr_d = gnt_inc;
               end else begin
                  state_d   = ST_LOCKED;
                  lock_ch_d = gnt;
               end
            end
            ST_LOCKED: begin
               if (gnt_last) begin
                  state_d = ST_IDLE;
                  ptr_d   = gnt_inc;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         lock_ch_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_ch_q    <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         lock_ch_q   <= lock_ch_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         out_ch_q    <= out_ch_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign out_last_o  = out_last_q;
   assign out_ch_o    = out_ch_q;
   assign busy_o      = (state_q == ST_LOCKED);

endmodule
